mix_columns_engine: RTL and testbench
=====================================

// Module: mix_columns_engine
// PURPOSE
//  Sequential, parametrised AES (Inv)MixColumns engine for the iterative round datapath.
//  Forward or inverse mode is selected per block. The block runs COLS_PER_CYCLE columns
//  per clock and uses a valid/ready handshake on both sides. It sits between ShiftRows/
//  InvShiftRows and AddRoundKey, so cipher and decipher share one area-scalable unit.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns processed per clock; legal 1,2,4 (else $error at elaboration)
//  N_STEPS         4/COLS_PER_CYCLE  localparam, BUSY cycles per block
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    state_in/inverse valid
//  in_ready   out  1    engine can accept a block this cycle
//  inverse    in   1    0 = MixColumns {02,03,01,01}; 1 = InvMixColumns {0e,0b,0d,09}
//  state_in   in   128  column c = [c*32+:32]; row0 byte = [c*32+24+:8], row3 = [c*32+:8]
//  out_valid  out  1    state_out holds a finished block
//  out_ready  in   1    consumer takes the block
//  state_out  out  128  result, same byte layout as state_in
//  busy       out  1    high in BUSY
// BEHAVIOUR
//  - Reset values: state=IDLE, out_valid=0, busy=0, state_out=0, col_cnt=0. in_ready=1
//    once rst is released.
//  - FSM IDLE -> BUSY -> DONE:
//    IDLE: in_ready=1. On in_valid&&in_ready, latch state_in into src_q and inverse
//      into mode_q, set col_cnt=0, go to BUSY.
//    BUSY: each cycle, columns col_cnt*C .. col_cnt*C+C-1 of src_q pass through the
//      column unit in mode_q. Results are written to the same columns of state_out.
//      col_cnt increments. After step N_STEPS-1, go to DONE.
//    DONE: out_valid=1; state_out is stable. On out_ready, clear out_valid. If in_valid
//      is also high, accept the new block and go to BUSY; otherwise go to IDLE.
//  - in_ready = (IDLE) | (DONE & out_ready). Back-to-back blocks take N_STEPS+1 cycles
//    per block.
//  - Latency: block accepted on edge k gives out_valid=1 after edge k+N_STEPS.
//  - inverse and state_in are sampled only at accept. Changes during BUSY/DONE are ignored.
//  - While BUSY, columns of state_out not yet written hold stale data. Consumers use
//    state_out only when out_valid=1.
//  - in_valid while not ready: nothing is latched. The producer holds the data.
//  - Column math uses GF(2^8) with poly 0x11b, out_r = XOR_j M[r][j]*s_j, where
//    M = circulant(02,03,01,01) forward and circulant(0e,0b,0d,09) inverse. Every
//    product is built from xtime chains: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
//  - rst asserted mid-operation aborts at once. All state returns to reset values and
//    the partial result is discarded.
// STRUCTURE
//  - aes_pkg: localparam AES_POLY=8'h1b; function xtime(byte); functions gmul2/3/9/b/d/e;
//    typedef-free constants COL_W=32, BLK_W=128.
//  - Sub-module mix_column_unit (combinational, one column, inverse input).
//    COLS_PER_CYCLE copies are instantiated by generate. Column select uses col_cnt
//    with an indexed part-select.
//  - FSM, counters and registers live in this top module only.
// TESTING
//  1. Fwd, C=1, column0=db135345, others 01010101 -> col0=8e4da1bc, others 01010101;
//     out_valid exactly 4 cycles after accept.
//  2. Inv, C=4, column f2 0a 22 5c result fed back (9fdc589d) -> returns f20a225c;
//     latency 1 cycle.
//  3. Round trip on all 3 C values with 1000 random blocks: fwd then inv == input.
//     Results must match a reference model.
//  4. Backpressure: out_ready low for 5 cycles in DONE -> state_out/out_valid held,
//     in_ready=0. When out_ready=1 with in_valid=1, the next block is accepted that
//     same cycle.
//  5. Toggle inverse and state_in during BUSY -> result unchanged (c6c6c6c6 -> c6c6c6c6;
//     d4d4d4d5 fwd -> d5d5d7d6).
//  6. Assert rst on the 2nd BUSY cycle -> out_valid=0, state_out=0, in_ready=1 after
//     release. No stale output appears.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers and widths for the AES MixColumns datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam int COL_W = 32;
    localparam int BLK_W = 128;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // 09 = 8 + 1
    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    // 0b = 8 + 2 + 1
    function automatic logic [7:0] gmulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    // 0d = 8 + 4 + 1
    function automatic logic [7:0] gmuld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    // 0e = 8 + 4 + 2
    function automatic logic [7:0] gmule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational (Inv)MixColumns for a single 32-bit column; row0 in the top byte.
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    input  logic             inverse,
    output logic [COL_W-1:0] result
);

    logic [7:0] s0, s1, s2, s3;

    assign s0 = col[31:24];
    assign s1 = col[23:16];
    assign s2 = col[15:8];
    assign s3 = col[7:0];

    // Circulant matrix product, forward {02,03,01,01} or inverse {0e,0b,0d,09}
    always_comb begin
        result = '0;
        if (inverse) begin
            result[31:24] = gmule(s0) ^ gmulb(s1) ^ gmuld(s2) ^ gmul9(s3);
            result[23:16] = gmul9(s0) ^ gmule(s1) ^ gmulb(s2) ^ gmuld(s3);
            result[15:8]  = gmuld(s0) ^ gmul9(s1) ^ gmule(s2) ^ gmulb(s3);
            result[7:0]   = gmulb(s0) ^ gmuld(s1) ^ gmul9(s2) ^ gmule(s3);
        end else begin
            result[31:24] = gmul2(s0) ^ gmul3(s1) ^ s2 ^ s3;
            result[23:16] = s0 ^ gmul2(s1) ^ gmul3(s2) ^ s3;
            result[15:8]  = s0 ^ s1 ^ gmul2(s2) ^ gmul3(s3);
            result[7:0]   = gmul3(s0) ^ s1 ^ s2 ^ gmul2(s3);
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative (Inv)MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready both sides.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             inverse,
    input  logic [BLK_W-1:0] state_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] state_out,
    output logic             busy
);

    localparam int unsigned N_STEPS = 4 / COLS_PER_CYCLE;
    localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int          SLICE_W = int'(COLS_PER_CYCLE) * COL_W;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [BLK_W-1:0] src_q;
    logic             mode_q;
    logic [CNT_W-1:0] col_cnt;
    logic [SLICE_W-1:0] src_sel;
    logic [SLICE_W-1:0] res_sel;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign src_sel  = src_q[int'(col_cnt) * SLICE_W +: SLICE_W];

    for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_col
        mix_column_unit u_col (
            .col    (src_sel[g*COL_W +: COL_W]),
            .inverse(mode_q),
            .result (res_sel[g*COL_W +: COL_W])
        );
    end

    // Control FSM plus source/result registers; a new block may be taken straight out of DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src_q     <= '0;
            mode_q    <= 1'b0;
            col_cnt   <= '0;
            state_out <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        src_q   <= state_in;
                        mode_q  <= inverse;
                        col_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    state_out[int'(col_cnt) * SLICE_W +: SLICE_W] <= res_sel;
                    if (col_cnt == LAST_STEP) begin
                        col_cnt   <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            src_q   <= state_in;
                            mode_q  <= inverse;
                            col_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench: three engine instances (1, 2, 4 columns per cycle) against a GF model.
module tb_mix_columns_engine;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         inverse   [3];
    logic [127:0] state_in  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];
    logic         busy      [3];

    int errors;
    int checks;
    int steps [3];

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .inverse(inverse[0]), .state_in(state_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .state_out(state_out[0]), .busy(busy[0])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .inverse(inverse[1]), .state_in(state_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .state_out(state_out[1]), .busy(busy[1])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .inverse(inverse[2]), .state_in(state_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .state_out(state_out[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: schoolbook polynomial multiply then reduce by 0x11b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(coef[(j - row + 4) % 4], s[c*32 + 24 - 8*j +: 8]);
                r[c*32 + 24 - 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Push one block into instance i, scramble its inputs while it works, collect and drain
    task automatic run_block(input int i, input logic [127:0] d, input logic inv,
                             output logic [127:0] res, output int lat);
        int n;
        in_valid[i]  = 1'b1;
        state_in[i]  = d;
        inverse[i]   = inv;
        out_ready[i] = 1'b0;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        lat = 0;
        while (!out_valid[i] && lat < 50) begin
            state_in[i] = rand128();
            inverse[i]  = $urandom_range(0, 1) != 0;
            @(posedge clk); #1; lat++;
        end
        res = state_out[i];
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; inverse[i] = 1'b0; state_in[i] = '0; out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || state_out[i] !== 128'h0 ||
                in_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset[%0d]: out_valid=%b busy=%b in_ready=%b state_out=%h, required 0 0 1 0",
                         i, out_valid[i], busy[i], in_ready[i], state_out[i]);
            end
        end
    endtask

    task automatic test_fwd_known();
        logic [127:0] d, res, exp;
        int lat;
        d   = {32'h01010101, 32'h01010101, 32'h01010101, 32'hdb135345};
        exp = {32'h01010101, 32'h01010101, 32'h01010101, 32'h8e4da1bc};
        run_block(0, d, 1'b0, res, lat);
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL fwd_known: got %h, required %h", res, exp);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL fwd_latency: got %0d, required 4", lat);
        end
    endtask

    task automatic test_inv_known();
        logic [127:0] res, exp;
        int lat;
        exp = {4{32'hf20a225c}};
        run_block(2, {4{32'h9fdc589d}}, 1'b1, res, lat);
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL inv_known: got %h, required %h", res, exp);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL inv_latency: got %0d, required 1", lat);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] d, f, b;
        int lf, lb;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 1000; n++) begin
                d = rand128();
                run_block(i, d, 1'b0, f, lf);
                run_block(i, f, 1'b1, b, lb);
                checks++;
                if (f !== model_mix(d, 1'b0) || b !== model_mix(f, 1'b1) || b !== d ||
                    lf !== steps[i] || lb !== steps[i]) begin
                    errors++;
                    $display("FAIL round_trip[%0d]: in=%h fwd=%h (model %h) back=%h lat=%0d/%0d, required lat %0d",
                             i, d, f, model_mix(d, 1'b0), b, lf, lb, steps[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d, d2, exp;
        int lat;
        d   = rand128();
        exp = model_mix(d, 1'b0);
        in_valid[1] = 1'b1; state_in[1] = d; inverse[1] = 1'b0; out_ready[1] = 1'b0;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        lat = 0;
        while (!out_valid[1] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL bp_latency: got %0d, required 2", lat);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid[1] = (k % 2) == 1;
            state_in[1] = rand128();
            #1;
            checks++;
            if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || state_out[1] !== exp) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b state_out=%h, required 1 0 %h",
                         k, out_valid[1], in_ready[1], state_out[1], exp);
            end
            @(posedge clk); #1;
        end
        d2 = rand128();
        in_valid[1] = 1'b1; state_in[1] = d2; inverse[1] = 1'b1; out_ready[1] = 1'b1;
        #1;
        checks++;
        if (in_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready: in_ready=%b, required 1", in_ready[1]);
        end
        @(posedge clk); #1;
        in_valid[1] = 1'b0; out_ready[1] = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: out_valid=%b busy=%b, required 0 1", out_valid[1], busy[1]);
        end
        lat = 0;
        while (!out_valid[1] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (state_out[1] !== model_mix(d2, 1'b1) || lat !== 2) begin
            errors++;
            $display("FAIL bp_next: got %h lat=%0d, required %h lat=2",
                     state_out[1], lat, model_mix(d2, 1'b1));
        end
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
    endtask

    task automatic test_toggle_busy();
        logic [127:0] res;
        int lat;
        for (int m = 0; m < 2; m++) begin
            run_block(0, {4{32'hc6c6c6c6}}, m != 0, res, lat);
            checks++;
            if (res !== {4{32'hc6c6c6c6}}) begin
                errors++;
                $display("FAIL toggle_c6[%0d]: got %h, required %h", m, res, {4{32'hc6c6c6c6}});
            end
        end
        run_block(1, {4{32'hd4d4d4d5}}, 1'b0, res, lat);
        checks++;
        if (res !== {4{32'hd5d5d7d6}}) begin
            errors++;
            $display("FAIL toggle_d4: got %h, required %h", res, {4{32'hd5d5d7d6}});
        end
    endtask

    task automatic test_reset_abort();
        in_valid[0] = 1'b1; state_in[0] = rand128(); inverse[0] = 1'b0; out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || state_out[0] !== 128'h0) begin
            errors++;
            $display("FAIL abort_now: out_valid=%b busy=%b state_out=%h, required 0 0 0",
                     out_valid[0], busy[0], state_out[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: in_ready=%b, required 1", in_ready[0]);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid[0] !== 1'b0 || state_out[0] !== 128'h0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL abort_stale[%0d]: out_valid=%b busy=%b state_out=%h, required 0 0 0",
                         k, out_valid[0], busy[0], state_out[0]);
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        steps[0] = 4;
        steps[1] = 2;
        steps[2] = 1;
        test_reset();
        test_fwd_known();
        test_inv_known();
        test_toggle_busy();
        test_backpressure();
        test_round_trip();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
